gpio_in_debounce: RTL and testbench

// Input-side conditioner for the board GPIO path: the return direction of the

---
 rtl/gpio_in_debounce.sv | 83 ++++++++
 tb/tb_gpio_in_debounce.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: button synchroniser, debouncer and edge detector.
// Optional sticky press flags via `define GPIO_DEBOUNCE_STICKY_EN.
module gpio_in_debounce #(
    parameter int NumInputs      = 3,
    parameter int DebounceCycles = 6000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumInputs-1:0] btn_i,
    output logic [NumInputs-1:0] btn_o,
    output logic [NumInputs-1:0] rise_o,
    output logic [NumInputs-1:0] fall_o,
    input  logic [NumInputs-1:0] evt_clr_i,
    output logic [NumInputs-1:0] evt_o
);

    localparam int CntWidth = $clog2(DebounceCycles) + 1;
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    logic [NumInputs-1:0] s1;
    logic [NumInputs-1:0] s2;
    logic [CntWidth-1:0]  cnt [NumInputs];

    // two-flop synchroniser for the asynchronous button pins
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_i;
            s2 <= s1;
        end
    end

    // per-channel hold counter; a level is accepted after it persists
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_o  <= '0;
            rise_o <= '0;
            fall_o <= '0;
            for (int i = 0; i < NumInputs; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rise_o <= '0;
            fall_o <= '0;
            for (int i = 0; i < NumInputs; i++) begin
                if (s2[i] == btn_o[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CntMax) begin
                    btn_o[i]  <= s2[i];
                    rise_o[i] <= s2[i];
                    fall_o[i] <= ~s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CntOne;
                end
            end
        end
    end

`ifdef GPIO_DEBOUNCE_STICKY_EN
    logic [NumInputs-1:0] evt_q;

    // sticky flag set by a visible rise pulse; set beats a same-cycle clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt_q <= '0;
        end else begin
            evt_q <= rise_o | (evt_q & ~evt_clr_i);
        end
    end

    assign evt_o = evt_q;
`else
    logic unused_evt_clr;

    assign unused_evt_clr = ^evt_clr_i;
    assign evt_o          = '0;
`endif

endmodule

// File: tb/tb_gpio_in_debounce.sv
// tb_gpio_in_debounce: scoreboard bench with a window-based reference model.
// Expected outputs are queued per edge and checked by a separate monitor.
module tb_gpio_in_debounce;

    localparam int N = 3;
    localparam int D = 4;

`ifdef GPIO_DEBOUNCE_STICKY_EN
    localparam bit Sticky = 1'b1;
`else
    localparam bit Sticky = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] evt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] clr = '0;
    logic [N-1:0] btn_o;
    logic [N-1:0] rise_o;
    logic [N-1:0] fall_o;
    logic [N-1:0] evt_o;

    int checks   = 0;
    int failures = 0;
    int rise_cnt [N];
    int fall_cnt [N];

    exp_t sb [$];

    // reference model state: accepted level, last pulses, sticky flags,
    // samples still travelling through the synchroniser, and the window of
    // the last D synchronised samples seen by the debouncer
    logic [N-1:0] m_out;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_fall;
    logic [N-1:0] m_evt;
    logic [N-1:0] pipe [$];
    logic [N-1:0] seen [$];

    always #5 clk = ~clk;

    gpio_in_debounce #(
        .NumInputs     (N),
        .DebounceCycles(D)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .btn_i    (btn),
        .btn_o    (btn_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .evt_clr_i(clr),
        .evt_o    (evt_o)
    );

    // model one clock edge using the inputs present at that edge
    task automatic model_step();
        logic [N-1:0] s;
        logic [N-1:0] nr;
        logic [N-1:0] nf;
        logic [N-1:0] ne;
        bit           all;
        exp_t         e;
        if (rst) begin
            m_out  = '0;
            m_rise = '0;
            m_fall = '0;
            m_evt  = '0;
            pipe   = {};
            pipe.push_back('0);
            pipe.push_back('0);
            seen   = {};
        end else begin
            s = pipe.pop_front();
            pipe.push_back(btn);
            seen.push_back(s);
            if (seen.size() > D) void'(seen.pop_front());
            ne = Sticky ? (m_rise | (m_evt & ~clr)) : '0;
            nr = '0;
            nf = '0;
            if (seen.size() == D) begin
                for (int c = 0; c < N; c++) begin
                    all = 1'b1;
                    foreach (seen[j]) begin
                        if (seen[j][c] == m_out[c]) all = 1'b0;
                    end
                    if (all) begin
                        nr[c] = ~m_out[c];
                        nf[c] = m_out[c];
                    end
                end
            end
            m_out  = m_out ^ (nr | nf);
            m_rise = nr;
            m_fall = nf;
            m_evt  = ne;
        end
        e.lvl  = m_out;
        e.rise = m_rise;
        e.fall = m_fall;
        e.evt  = m_evt;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic [N-1:0] b, input logic r,
                       input logic [N-1:0] c);
        @(negedge clk);
        btn = b;
        rst = r;
        clr = c;
        @(posedge clk);
        model_step();
    endtask

    task automatic hold(input logic [N-1:0] b, input int n);
        for (int i = 0; i < n; i++) cyc(b, 1'b0, '0);
    endtask

    task automatic clr_counts();
        for (int c = 0; c < N; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // monitor: compare every presented output vector against the queue
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int c = 0; c < N; c++) begin
                    if (rise_o[c] === 1'b1) rise_cnt[c]++;
                    if (fall_o[c] === 1'b1) fall_cnt[c]++;
                end
                checks++;
                if (btn_o !== e.lvl) begin
                    failures++;
                    $display("FAIL btn_o t=%0t: got %b expected %b",
                             $time, btn_o, e.lvl);
                end
                checks++;
                if (rise_o !== e.rise) begin
                    failures++;
                    $display("FAIL rise_o t=%0t: got %b expected %b",
                             $time, rise_o, e.rise);
                end
                checks++;
                if (fall_o !== e.fall) begin
                    failures++;
                    $display("FAIL fall_o t=%0t: got %b expected %b",
                             $time, fall_o, e.fall);
                end
                checks++;
                if (evt_o !== e.evt) begin
                    failures++;
                    $display("FAIL evt_o t=%0t: got %b expected %b",
                             $time, evt_o, e.evt);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] b;
        logic [N-1:0] c;
        logic         r;

        // reset with all buttons held, then release
        for (int i = 0; i < 3; i++) cyc('1, 1'b1, '0);
        hold('1, 2);
        hold('0, 10);
        #2;
        chk("reset_lvl", int'(btn_o), 0);

        // single press on channel 0
        clr_counts();
        hold(3'b001, 10);
        #2;
        chk("press_lvl0", int'(btn_o[0]), 1);
        chk("press_rise0", rise_cnt[0], 1);

        // short glitch on channel 1
        clr_counts();
        hold(3'b011, 3);
        hold(3'b001, 10);
        #2;
        chk("glitch_lvl1", int'(btn_o[1]), 0);
        chk("glitch_rise1", rise_cnt[1], 0);
        chk("glitch_fall1", fall_cnt[1], 0);

        // bouncing channel 2, then stable press and stable release
        clr_counts();
        for (int i = 0; i < 20; i++) begin
            b = 3'b001;
            b[2] = i[1];
            cyc(b, 1'b0, '0);
        end
        hold(3'b101, 10);
        #2;
        chk("bounce_rise2", rise_cnt[2], 1);
        chk("bounce_lvl2", int'(btn_o[2]), 1);
        hold(3'b001, 10);
        #2;
        chk("bounce_fall2", fall_cnt[2], 1);

        // reset in the middle of a debounce interval
        hold(3'b000, 10);
        clr_counts();
        hold(3'b001, 3);
        cyc(3'b001, 1'b1, '0);
        hold(3'b001, 10);
        #2;
        chk("rstmid_rise0", rise_cnt[0], 1);
        chk("rstmid_lvl0", int'(btn_o[0]), 1);

        // sticky flag: set, clear during a rise, then plain clear
        hold(3'b000, 10);
        for (int i = 0; i < 10; i++) begin
            c = (i == 6) ? 3'b001 : 3'b000;
            cyc(3'b001, 1'b0, c);
        end
        #2;
        chk("sticky_set", int'(evt_o[0]), Sticky ? 1 : 0);
        cyc(3'b001, 1'b0, 3'b001);
        cyc(3'b001, 1'b0, 3'b000);
        #2;
        chk("sticky_clr", int'(evt_o[0]), 0);

        // randomised long run with slow-changing levels and rare resets
        b = 3'b001;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(7) == 0) b[k] = ~b[k];
            end
            c = N'($urandom_range((1 << N) - 1));
            if ($urandom_range(3) != 0) c = '0;
            r = ($urandom_range(299) == 0);
            cyc(b, r, c);
        end

        hold('0, 2);
        #3;
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
